// File: rtl/sistema_speed.sv
// High-throughput micro-hash miner: a 32-stage round pipeline accepts one nonce per clock and
// latches the first (smallest) nonce whose hash meets the difficulty target.
module sistema_speed (
  input  logic        clk,
  input  logic        reset_L,
  input  logic [95:0] payload,
  input  logic        active,
  input  logic [7:0]  target,
  output logic        terminado,
  output logic [31:0] nonceOut,
  output logic [23:0] hashOut
);

  localparam logic [7:0] H0 = 8'h01;
  localparam logic [7:0] H1 = 8'h89;
  localparam logic [7:0] H2 = 8'hFE;

  typedef struct packed {
    logic             vld;
    logic [31:0]      nonce;
    logic [31:0][7:0] w;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       c;
  } stage_t;

  // Full 32-byte schedule is built once at injection and travels with the nonce.
  function automatic logic [31:0][7:0] expand(input logic [95:0] pl, input logic [31:0] n);
    logic [31:0][7:0] w;
    w = '0;
    for (int i = 0; i < 12; i++) w[i] = pl[95-8*i -: 8];
    for (int i = 0; i < 4; i++) w[12+i] = n[31-8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    return w;
  endfunction

  function automatic stage_t round_step(input stage_t s, input logic [4:0] idx);
    stage_t     r;
    logic [7:0] x;
    logic [7:0] k;
    r = s;
    if (idx <= 5'd16) begin
      x = s.a ^ s.b;
      k = 8'h99;
    end else begin
      x = s.a ^ s.b ^ s.c;
      k = 8'hA1;
    end
    r.a = s.b ^ s.c;
    r.b = {s.c[3:0], s.c[7:4]};
    r.c = x + k + s.w[idx];
    return r;
  endfunction

  stage_t      stage_q [32];
  stage_t      stage_d [32];
  logic [31:0] nonce_q, nonce_d;
  logic        terminado_q, terminado_d;
  logic [31:0] nonce_out_q, nonce_out_d;
  logic [23:0] hash_out_q, hash_out_d;

  stage_t      entry;
  stage_t      fin;
  logic [23:0] hash_fin;
  logic        win;

  always_comb begin
    entry       = '0;
    entry.vld   = active & ~terminado_q;
    entry.nonce = nonce_q;
    entry.w     = expand(payload, nonce_q);
    entry.a     = H0;
    entry.b     = H1;
    entry.c     = H2;
    stage_d[0]  = round_step(entry, 5'd0);
    for (int k = 1; k < 32; k++) begin
      stage_d[k]     = round_step(stage_q[k-1], 5'(k));
      stage_d[k].vld = stage_q[k-1].vld & active;
    end
  end

  always_comb begin
    fin      = stage_q[31];
    hash_fin = {H0 + fin.a, H1 + fin.b, H2 + fin.c};
    win      = fin.vld && (hash_fin[23:16] < target) && (hash_fin[15:8] < target);

    nonce_d     = nonce_q;
    terminado_d = terminado_q;
    nonce_out_d = nonce_out_q;
    hash_out_d  = hash_out_q;
    if (!active) begin
      nonce_d     = '0;
      terminado_d = 1'b0;
      nonce_out_d = '0;
      hash_out_d  = '0;
    end else if (!terminado_q) begin
      nonce_d = nonce_q + 32'd1;
      if (win) begin
        terminado_d = 1'b1;
        nonce_out_d = fin.nonce;
        hash_out_d  = hash_fin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < 32; k++) stage_q[k] <= '0;
      nonce_q     <= '0;
      terminado_q <= 1'b0;
      nonce_out_q <= '0;
      hash_out_q  <= '0;
    end else begin
      stage_q     <= stage_d;
      nonce_q     <= nonce_d;
      terminado_q <= terminado_d;
      nonce_out_q <= nonce_out_d;
      hash_out_q  <= hash_out_d;
    end
  end

  assign terminado = terminado_q;
  assign nonceOut  = nonce_out_q;
  assign hashOut   = hash_out_q;

endmodule

// File: tb/tb_sistema_speed.sv
// Bench for sistema_speed: a software hash/search model predicts winner, latency, sticky hold
// and counter value; a negedge process compares every cycle.
module tb_sistema_speed;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic [95:0] payload = '0;
  logic        active = 1'b0;
  logic [7:0]  target = '0;
  logic        terminado;
  logic [31:0] nonceOut;
  logic [23:0] hashOut;

  sistema_speed dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .payload  (payload),
    .active   (active),
    .target   (target),
    .terminado(terminado),
    .nonceOut (nonceOut),
    .hashOut  (hashOut)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          m = -1;       // active edges since E0 minus one; -1 when idle
  int          win = -1;     // model winner for current payload/target, -1 if none
  logic [23:0] win_hash = '0;
  logic        chk_on = 1'b0;

  function automatic logic [23:0] model_hash(input logic [95:0] p, input logic [31:0] n);
    logic [7:0]   w [32];
    logic [127:0] msg;
    logic [7:0]   a, b, c, x, k, t;
    msg = {p, n};
    for (int i = 0; i < 16; i++) w[i] = msg[127-8*i -: 8];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01;
    b = 8'h89;
    c = 8'hFE;
    for (int i = 0; i < 32; i++) begin
      k = (i < 17) ? 8'h99 : 8'hA1;
      x = (i < 17) ? (a ^ b) : (a ^ b ^ c);
      t = c;
      c = x + k + w[i];
      a = b ^ t;
      b = {t[3:0], t[7:4]};
    end
    return {8'h01 + a, 8'h89 + b, 8'hFE + c};
  endfunction

  function automatic int model_search(input logic [95:0] p, input logic [7:0] t, input int limit);
    logic [23:0] h;
    for (int n = 0; n < limit; n++) begin
      h = model_hash(p, 32'(n));
      if (h[23:16] < t && h[15:8] < t) return n;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L || !active) m = -1;
    else m = m + 1;
  end

  always @(negedge clk) begin
    logic        exp_term;
    logic [31:0] exp_cnt;
    if (chk_on) begin
      exp_term = reset_L && (m >= 0) && (win >= 0) && (m >= win + 32);
      if (m < 0) exp_cnt = '0;
      else if (exp_term) exp_cnt = 32'(win + 33);
      else exp_cnt = 32'(m + 1);
      chk("terminado", 64'(terminado), 64'(exp_term));
      chk("nonceOut", 64'(nonceOut), exp_term ? 64'(win) : 64'd0);
      chk("hashOut", 64'(hashOut), exp_term ? 64'(win_hash) : 64'd0);
      chk("counter", 64'(dut.nonce_q), 64'(exp_cnt));
    end
  end

  task automatic start(input logic [95:0] p, input logic [7:0] t);
    @(posedge clk);
    #1;
    payload  = p;
    target   = t;
    win      = model_search(p, t, 20000);
    win_hash = (win >= 0) ? model_hash(p, 32'(win)) : 24'h0;
    active   = 1'b1;
  endtask

  task automatic stop();
    @(posedge clk);
    #1;
    active = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    chk_on = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_L = 1'b1;

    // Hand-computed: all-zero message gives hash 68_D1_52.
    chk("model_pin", 64'(model_hash(96'h0, 32'h0)), 64'h68D152);

    // Zero payload, target D2: nonce 0 wins, result exactly 32 edges after E0.
    start(96'h0, 8'hD2);
    chk("pin_winner", 64'(win), 64'd0);
    repeat (32) @(posedge clk);
    #1;
    chk("pin_not_yet", 64'(terminado), 64'd0);
    @(posedge clk);
    #1;
    chk("pin_done", 64'(terminado), 64'd1);
    chk("pin_nonce", 64'(nonceOut), 64'd0);
    chk("pin_hash", 64'(hashOut), 64'h68D152);
    stop();

    // Golden search, then 100 sticky cycles.
    start(96'h397d9f2f40ca9e6c6b1f3324, 8'd10);
    chk("golden_found", 64'(win >= 0), 64'd1);
    repeat ((win >= 0) ? win + 133 : 2000) @(posedge clk);
    stop();

    // Loose target, then asynchronous reset mid-cycle.
    start(96'h397d9f2f40ca9e6c6b1f3324, 8'hFF);
    repeat ((win >= 0) ? win + 40 : 200) @(posedge clk);
    #1;
    chk("loose_done", 64'(terminado), 64'(win >= 0));
    #1;
    reset_L = 1'b0;
    active  = 1'b0;
    #1;
    chk("areset_term", 64'(terminado), 64'd0);
    chk("areset_nonce", 64'(nonceOut), 64'd0);
    chk("areset_hash", 64'(hashOut), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;

    // Unreachable target.
    start({$urandom, $urandom, $urandom}, 8'd0);
    repeat (2000) @(posedge clk);
    stop();

    // Drop active on the very edge the winner reaches the compare stage, then restart.
    start({$urandom, $urandom, $urandom}, 8'($urandom_range(64, 255)));
    if (win >= 0) begin
      repeat (win + 32) @(posedge clk);
      #1;
      active = 1'b0;
      @(posedge clk);
      #1;
      chk("drop_clears", 64'(terminado), 64'd0);
      active = 1'b1;
      repeat (win + 40) @(posedge clk);
    end
    stop();

    // Randomized payloads and targets.
    for (int r = 0; r < 6; r++) begin
      start({$urandom, $urandom, $urandom}, 8'($urandom_range(32, 255)));
      repeat ((win >= 0) ? win + 40 : 300) @(posedge clk);
      stop();
    end

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
